stdp_update_scheduler: RTL
==========================

Name: stdp_update_scheduler

Overview:
- Shares one STDP weight-update unit across N_SYN synapses driven by a common post-synaptic neuron.
- Tracks per-synapse pre-spike timers and one post-spike timer, and queues LTP/LTD requests.
- Serves queued requests one at a time with a round-robin arbiter and holds the weight register file.
- Sits between spike sources and the neuron datapath, which reads weights through the read port.

Parameters:
N_SYN, 4, number of synapses (power of 2, >=2)
TW, 8, timer width; timers saturate at 2^TW-1
WW, 8, weight width
WINDOW, 16, plasticity window; dt >= WINDOW gives no update
W_INIT, 16, weight value after reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  when 0, no new requests are queued and timers hold
pre_spike  in  N_SYN  per-synapse pre-synaptic spike, 1-cycle pulse
post_spike  in  1  post-synaptic spike, 1-cycle pulse
weight_rd_sel  in  log2(N_SYN)  weight read index
weight_rd  out  WW  combinational weight[weight_rd_sel]
busy  out  1  high when FSM not IDLE or any request pending
upd_valid  out  1  1-cycle pulse when a weight is written
upd_idx  out  log2(N_SYN)  synapse index of the update
upd_weight  out  WW  new weight value
overrun  out  1  1-cycle pulse when a request overwrites a pending one of the same type

Behaviour:
- Reset (async, any state) clears all state at once:
  - weights = W_INIT; pre/post timers = 2^TW-1; pending bits and dt regs = 0; rr_ptr = 0; state = IDLE.
  - All outputs 0 except weight_rd.
- Timers (en=1):
  - On the corresponding spike, the timer loads 0.
  - Otherwise it increments, saturating at 2^TW-1.
  - Spike at edge k, other spike sampled at edge k+d: sampled timer value = d-1.
- Request capture (en=1), using timer values before that edge's clear:
  - post_spike && pre_timer[i] < WINDOW: set ltp_pend[i], ltp_dt[i] = pre_timer[i].
  - pre_spike[i] && post_timer < WINDOW: set ltd_pend[i], ltd_dt[i] = post_timer.
  - pre_spike[i] and post_spike in the same cycle: set LTP only, dt = 0; no LTD.
  - Request on an already-pending bit of the same type: dt is overwritten and overrun pulses.
  - Set and clear of the same bit in one cycle: set wins, dt is the new value, no overrun.
- FSM:
  - IDLE: if any pending, grant the first synapse i with pending at or after rr_ptr (wrapping), then go to CALC.
  - CALC:
    - If ltp_pend[i]: type = LTP, otherwise LTD. LTP is served before LTD on the same synapse.
    - Compute new weight into a register and clear the served pending bit.
    - Go to WRITE.
  - WRITE:
    - upd_valid = 1, upd_idx = i, upd_weight = new value.
    - Weight array is written at the edge leaving WRITE.
    - rr_ptr = (i+1) mod N_SYN. Go to IDLE.
- Latency: post_spike sampled at edge k gives upd_valid high in the cycle after edge k+2. weight_rd reflects the new value after edge k+3.
- Throughput: one update per 3 cycles.
- Delta table by dt: dt<2 gives 8; dt<4 gives 4; dt<8 gives 2; dt<WINDOW gives 1.
  - LTP adds the delta, saturating at 2^WW-1.
  - LTD subtracts the delta, saturating at 0.
  - Arithmetic is done at WW+1 bits, then clamped.
- en=0:
  - Timers hold and no captures occur.
  - The FSM keeps draining existing requests.
- Pending bits persist indefinitely. There is no timeout.

Test Plan:
1. Assert rst mid-operation (state WRITE), asynchronously, between clock edges -> outputs clear without waiting for a clock edge; after release all weight_rd = 16, busy = 0, upd_valid = 0.
2. pre_spike[0] at edge k, post_spike at edge k+3 (dt = 2) -> upd_valid in the cycle after edge k+5 with upd_idx = 0 and upd_weight = 20; weight_rd(sel 0) = 20 afterwards.
3. pre_spike[3:0] = 1111 at edge k, post_spike at edge k+1 -> four updates every 3 cycles, idx 0,1,2,3, each weight 24; a following burst starts at idx 0.
4. Saturation: synapse 1 driven to 250, then LTP with dt = 0 -> 255. Synapse 2 at 3, then pre_spike[2] one cycle after post_spike (dt = 0) -> weight 0.
5. Synapse 2 LTP pending while the FSM serves synapses 0 and 1, then a second post_spike -> overrun pulses once; synapse 2 receives exactly one update using the second dt.
6. en = 0 with spikes applied -> no upd_valid and timers frozen; a pending request queued before en fell still completes.

Source files
------------

// File: rtl/stdp_update_scheduler.sv
// STDP update scheduler: per-synapse pre/post spike timers, LTP/LTD request queue,
// and one shared weight-update unit served round-robin over the weight register file.
module stdp_update_scheduler #(
  parameter int N_SYN  = 4,
  parameter int TW     = 8,
  parameter int WW     = 8,
  parameter int WINDOW = 16,
  parameter int W_INIT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_SYN-1:0]         pre_spike,
  input  logic                     post_spike,
  input  logic [$clog2(N_SYN)-1:0] weight_rd_sel,
  output logic [WW-1:0]            weight_rd,
  output logic                     busy,
  output logic                     upd_valid,
  output logic [$clog2(N_SYN)-1:0] upd_idx,
  output logic [WW-1:0]            upd_weight,
  output logic                     overrun
);
  localparam int IW = $clog2(N_SYN);
  localparam logic [TW:0] WIN = (TW+1)'(WINDOW);

  typedef enum logic [1:0] {IDLE, CALC, WRITE} state_t;
  state_t state, state_nx;

  logic [TW-1:0]    pre_timer [N_SYN];
  logic [TW-1:0]    post_timer;
  logic [WW-1:0]    weight    [N_SYN];
  logic [TW-1:0]    ltp_dt    [N_SYN];
  logic [TW-1:0]    ltd_dt    [N_SYN];
  logic [N_SYN-1:0] ltp_pend, ltd_pend, ltp_set, ltd_set, ltp_clr, ltd_clr;
  logic [IW-1:0]    rr_ptr, grant, grant_nx;
  logic [WW-1:0]    new_w, calc_w;
  logic             overrun_r, overrun_nx, any_pend, found, serve_ltp;
  logic [TW-1:0]    dt_sel;
  logic [WW:0]      delta, wide;
  logic [IW-1:0]    cand;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  // Captures see the timer values from before this edge's spike clear.
  always_comb begin
    ltp_set = '0;
    ltd_set = '0;
    for (int unsigned i = 0; i < N_SYN; i++) begin
      if (en && post_spike && (pre_spike[i] || ({1'b0, pre_timer[i]} < WIN)))
        ltp_set[i] = 1'b1;
      if (en && pre_spike[i] && !post_spike && ({1'b0, post_timer} < WIN))
        ltd_set[i] = 1'b1;
    end
  end

  always_comb begin
    serve_ltp = ltp_pend[grant];
    ltp_clr   = '0;
    ltd_clr   = '0;
    if (state == CALC) begin
      if (serve_ltp) ltp_clr = N_SYN'(1) << grant;
      else           ltd_clr = N_SYN'(1) << grant;
    end
    overrun_nx = |((ltp_set & ltp_pend & ~ltp_clr) | (ltd_set & ltd_pend & ~ltd_clr));
  end

  always_comb begin
    any_pend = |(ltp_pend | ltd_pend);
    grant_nx = rr_ptr;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned k = 0; k < N_SYN; k++) begin
      cand = rr_ptr + IW'(k);
      if (!found && (ltp_pend[cand] || ltd_pend[cand])) begin
        grant_nx = cand;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    dt_sel = serve_ltp ? ltp_dt[grant] : ltd_dt[grant];
    if      ({1'b0, dt_sel} < (TW+1)'(2)) delta = (WW+1)'(8);
    else if ({1'b0, dt_sel} < (TW+1)'(4)) delta = (WW+1)'(4);
    else if ({1'b0, dt_sel} < (TW+1)'(8)) delta = (WW+1)'(2);
    else if ({1'b0, dt_sel} < WIN)        delta = (WW+1)'(1);
    else                                  delta = '0;
    wide = serve_ltp ? ({1'b0, weight[grant]} + delta) : ({1'b0, weight[grant]} - delta);
    if (!wide[WW])      calc_w = wide[WW-1:0];
    else if (serve_ltp) calc_w = '1;
    else                calc_w = '0;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_pend) state_nx = CALC;
      CALC:    state_nx = WRITE;
      WRITE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      post_timer <= '1;
      ltp_pend   <= '0;
      ltd_pend   <= '0;
      rr_ptr     <= '0;
      grant      <= '0;
      new_w      <= '0;
      overrun_r  <= 1'b0;
      for (int unsigned i = 0; i < N_SYN; i++) begin
        pre_timer[i] <= '1;
        weight[i]    <= WW'(W_INIT);
        ltp_dt[i]    <= '0;
        ltd_dt[i]    <= '0;
      end
    end else begin
      state     <= state_nx;
      overrun_r <= overrun_nx;
      ltp_pend  <= (ltp_pend & ~ltp_clr) | ltp_set;
      ltd_pend  <= (ltd_pend & ~ltd_clr) | ltd_set;
      if (en) post_timer <= post_spike ? '0 : sat_inc(post_timer);
      for (int unsigned i = 0; i < N_SYN; i++) begin
        if (en) pre_timer[i] <= pre_spike[i] ? '0 : sat_inc(pre_timer[i]);
        if (ltp_set[i]) ltp_dt[i] <= pre_spike[i] ? '0 : pre_timer[i];
        if (ltd_set[i]) ltd_dt[i] <= post_timer;
      end
      if (state == IDLE && any_pend) grant <= grant_nx;
      if (state == CALC) new_w <= calc_w;
      if (state == WRITE) begin
        weight[grant] <= new_w;
        rr_ptr        <= grant + 1'b1;
      end
    end
  end

  assign weight_rd  = weight[weight_rd_sel];
  assign busy       = (state != IDLE) || any_pend;
  assign upd_valid  = (state == WRITE);
  assign upd_idx    = (state == WRITE) ? grant : '0;
  assign upd_weight = (state == WRITE) ? new_w : '0;
  assign overrun    = overrun_r;
endmodule
